// File: rtl/dealer_pkg.sv
// Shared types and helpers for the card dealer and other blackjack blocks.
package dealer_pkg;

    localparam int DECK_SIZE = 52;
    localparam int RANKS     = 13;

    typedef struct packed {
        logic [1:0] suit;
        logic [3:0] rank;
    } card_t;

    typedef enum logic [1:0] {
        EMPTY,
        FILL,
        SHUFFLE,
        READY
    } dealer_state_t;

    // Blackjack value of a rank: ace counts 1 here, faces count 10.
    function automatic logic [4:0] rank_to_points(input logic [3:0] rank);
        if (rank > 4'd10) begin
            return 5'd10;
        end
        return {1'b0, rank};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1.
module lfsr16 (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;

    // Right-shifting Galois form: the bit shifted out is fed back into the tap positions.
    always_comb begin
        lfsr_d = {1'b0, lfsr_q[15:1]};
        if (lfsr_q[0]) begin
            lfsr_d = lfsr_d ^ 16'hB400;
        end
    end

    // Load the seed on reset, otherwise step every cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign out = lfsr_q;

endmodule

// File: rtl/card_dealer.sv
// Deck server: fills a 52-card deck, shuffles it in place with an
// LFSR-driven Fisher-Yates pass and deals one card per draw request.
//
// state   | meaning
// EMPTY   | no cards; waiting for a shuffle request
// FILL    | writing the ordered deck, one card per cycle
// SHUFFLE | Fisher-Yates swaps from the top index down to 1
// READY   | dealing cards from rd_ptr
module card_dealer #(
    parameter int          DECK_SIZE = dealer_pkg::DECK_SIZE,
    parameter int          IDX_W     = 6,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             shuffle_req,
    input  logic             draw_req,
    output logic             card_valid,
    output logic [3:0]       card_rank,
    output logic [1:0]       card_suit,
    output logic [4:0]       card_points,
    output logic             card_is_ace,
    output logic             draw_err,
    output logic             deck_ready,
    output logic             busy,
    output logic [IDX_W-1:0] cards_left
);

    import dealer_pkg::*;

    // Smallest all-ones value covering i: smear the highest set bit downwards.
    function automatic logic [IDX_W-1:0] idx_mask(input logic [IDX_W-1:0] i);
        logic [IDX_W-1:0] m;
        m = i;
        for (int b = 1; b < IDX_W; b++) begin
            m = m | (m >> b);
        end
        return m;
    endfunction

    dealer_state_t    state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [IDX_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [IDX_W-1:0] cards_left_q, cards_left_d;
    logic [3:0]       fill_rank_q, fill_rank_d;
    logic [1:0]       fill_suit_q, fill_suit_d;
    card_t            card_q, card_d;
    logic             card_valid_q, card_valid_d;
    logic             draw_err_q, draw_err_d;

    card_t            deck_q [DECK_SIZE];
    logic             fill_we;
    logic             swap_en;
    logic [15:0]      lfsr_w;
    logic [IDX_W-1:0] swap_j;

    lfsr16 u_lfsr (
        .clk  (clk),
        .rst  (rst),
        .seed (LFSR_SEED),
        .out  (lfsr_w)
    );

    // idx_q is the fill index k in FILL and the Fisher-Yates index i in SHUFFLE.
    assign swap_j = lfsr_w[IDX_W-1:0] & idx_mask(idx_q);

    // Next-state and datapath control.
    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        rd_ptr_d     = rd_ptr_q;
        cards_left_d = cards_left_q;
        fill_rank_d  = fill_rank_q;
        fill_suit_d  = fill_suit_q;
        card_d       = card_q;
        card_valid_d = 1'b0;
        draw_err_d   = draw_req && !(state_q == READY && !shuffle_req);
        fill_we      = 1'b0;
        swap_en      = 1'b0;

        case (state_q)
            EMPTY: begin
                if (shuffle_req) begin
                    state_d      = FILL;
                    idx_d        = '0;
                    fill_rank_d  = 4'd1;
                    fill_suit_d  = 2'd0;
                    cards_left_d = '0;
                end
            end
            FILL: begin
                fill_we = 1'b1;
                if (idx_q == IDX_W'(DECK_SIZE - 1)) begin
                    // idx already holds the first shuffle index.
                    state_d = SHUFFLE;
                end else begin
                    idx_d = idx_q + 1'b1;
                    if (fill_rank_q == 4'(RANKS)) begin
                        fill_rank_d = 4'd1;
                        fill_suit_d = fill_suit_q + 1'b1;
                    end else begin
                        fill_rank_d = fill_rank_q + 1'b1;
                    end
                end
            end
            SHUFFLE: begin
                // Out-of-range candidates are rejected and retried with the next LFSR value.
                if (swap_j <= idx_q) begin
                    swap_en = 1'b1;
                    idx_d   = idx_q - 1'b1;
                    if (idx_q <= IDX_W'(1)) begin
                        state_d      = READY;
                        cards_left_d = IDX_W'(DECK_SIZE);
                        rd_ptr_d     = '0;
                    end
                end
            end
            READY: begin
                if (shuffle_req) begin
                    state_d      = FILL;
                    idx_d        = '0;
                    fill_rank_d  = 4'd1;
                    fill_suit_d  = 2'd0;
                    cards_left_d = '0;
                end else if (draw_req) begin
                    card_d       = deck_q[rd_ptr_q];
                    card_valid_d = 1'b1;
                    rd_ptr_d     = rd_ptr_q + 1'b1;
                    cards_left_d = cards_left_q - 1'b1;
                    if (cards_left_q == IDX_W'(1)) begin
                        state_d = EMPTY;
                    end
                end
            end
            default: begin
                state_d = EMPTY;
            end
        endcase
    end

    // Control and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            idx_q        <= '0;
            rd_ptr_q     <= '0;
            cards_left_q <= '0;
            fill_rank_q  <= 4'd1;
            fill_suit_q  <= 2'd0;
            card_q       <= '0;
            card_valid_q <= 1'b0;
            draw_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            rd_ptr_q     <= rd_ptr_d;
            cards_left_q <= cards_left_d;
            fill_rank_q  <= fill_rank_d;
            fill_suit_q  <= fill_suit_d;
            card_q       <= card_d;
            card_valid_q <= card_valid_d;
            draw_err_q   <= draw_err_d;
        end
    end

    // Deck storage; contents are meaningless until a fill completes, so no reset.
    always_ff @(posedge clk) begin
        if (fill_we) begin
            deck_q[idx_q] <= {fill_suit_q, fill_rank_q};
        end else if (swap_en) begin
            deck_q[idx_q]  <= deck_q[swap_j];
            deck_q[swap_j] <= deck_q[idx_q];
        end
    end

    assign card_valid  = card_valid_q;
    assign card_rank   = card_q.rank;
    assign card_suit   = card_q.suit;
    assign card_points = rank_to_points(card_q.rank);
    assign card_is_ace = (card_q.rank == 4'd1);
    assign draw_err    = draw_err_q;
    assign deck_ready  = (state_q == READY);
    assign busy        = (state_q == FILL) || (state_q == SHUFFLE);
    assign cards_left  = cards_left_q;

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer with a behavioural shuffle model.
module tb_card_dealer;

    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       shuffle_req = 1'b0;
    logic       draw_req = 1'b0;
    logic       card_valid;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic [4:0] card_points;
    logic       card_is_ace;
    logic       draw_err;
    logic       deck_ready;
    logic       busy;
    logic [5:0] cards_left;

    int checks = 0;
    int errors = 0;

    logic [15:0] lfsr_m;
    int exp_rank [52];
    int exp_suit [52];
    int got_rank [52];
    int got_suit [52];
    int deal_pos;
    int ncyc;
    logic [15:0] l0;

    card_dealer #(.DECK_SIZE(52), .IDX_W(6), .LFSR_SEED(SEED)) dut (
        .clk         (clk),
        .rst         (rst),
        .shuffle_req (shuffle_req),
        .draw_req    (draw_req),
        .card_valid  (card_valid),
        .card_rank   (card_rank),
        .card_suit   (card_suit),
        .card_points (card_points),
        .card_is_ace (card_is_ace),
        .draw_err    (draw_err),
        .deck_ready  (deck_ready),
        .busy        (busy),
        .cards_left  (cards_left)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] step(input logic [15:0] l);
        return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
    endfunction

    function automatic int mask_of(input int i);
        int m = 0;
        while (m < i) m = m * 2 + 1;
        return m;
    endfunction

    // Reference LFSR tracking the DUT's register value cycle by cycle.
    always @(posedge clk) lfsr_m <= rst ? SEED : step(lfsr_m);

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("check %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Shuffle reference: l_req is the LFSR value in the cycle shuffle_req is sampled.
    task automatic build_model(input logic [15:0] l_req, output int cyc);
        logic [15:0] l;
        int i, j, t;
        l = l_req;
        for (int c = 0; c < 53; c++) l = step(l);
        for (int k = 0; k < 52; k++) begin
            exp_rank[k] = k % 13 + 1;
            exp_suit[k] = k / 13;
        end
        i = 51;
        cyc = 0;
        while (i > 0 && cyc < 10000) begin
            j = int'(l[5:0]) & mask_of(i);
            cyc++;
            if (j <= i) begin
                t = exp_rank[i]; exp_rank[i] = exp_rank[j]; exp_rank[j] = t;
                t = exp_suit[i]; exp_suit[i] = exp_suit[j]; exp_suit[j] = t;
                i--;
            end
            l = step(l);
        end
    endtask

    // Called one negedge after the shuffle request edge; follows busy until READY.
    task automatic wait_ready(input logic inj_shuf, input logic inj_draw, input int shuf_cyc);
        int cnt = 0;
        while (busy === 1'b1 && cnt < 3000) begin
            cnt++;
            if (inj_draw && cnt == 6) begin
                chk("busy_draw_err", draw_err, 1);
                chk("busy_draw_valid", card_valid, 0);
            end
            shuffle_req = inj_shuf && (cnt == 20 || cnt == 60);
            draw_req    = inj_draw && (cnt == 5);
            @(negedge clk);
        end
        shuffle_req = 1'b0;
        draw_req    = 1'b0;
        chk("busy_cycles", cnt, 52 + shuf_cyc);
        chk("ready_flag", deck_ready, 1);
        chk("ready_busy", busy, 0);
        chk("ready_cards_left", cards_left, 52);
        deal_pos = 0;
    endtask

    task automatic start_shuffle(output int cyc);
        shuffle_req = 1'b1;
        build_model(lfsr_m, cyc);
        @(negedge clk);
        shuffle_req = 1'b0;
        chk("start_busy", busy, 1);
        chk("start_cards_left", cards_left, 0);
    endtask

    task automatic deal(input int n);
        int r;
        draw_req = 1'b1;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (c == n - 1) draw_req = 1'b0;
            r = exp_rank[deal_pos];
            chk("deal_valid", card_valid, 1);
            chk("deal_rank", card_rank, r);
            chk("deal_suit", card_suit, exp_suit[deal_pos]);
            chk("deal_points", card_points, (r > 10) ? 10 : r);
            chk("deal_ace", card_is_ace, (r == 1) ? 1 : 0);
            chk("deal_cards_left", cards_left, 51 - deal_pos);
            chk("deal_err", draw_err, 0);
            got_rank[deal_pos] = int'(card_rank);
            got_suit[deal_pos] = int'(card_suit);
            deal_pos++;
        end
    endtask

    task automatic draw_expect_err(input string tag);
        draw_req = 1'b1;
        @(negedge clk);
        draw_req = 1'b0;
        chk({tag, "_err"}, draw_err, 1);
        chk({tag, "_valid"}, card_valid, 0);
    endtask

    initial begin
        int seen [52];
        int rank_cnt [14];
        int aces, dups, bad;

        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_valid", card_valid, 0);
        chk("rst_rank", card_rank, 0);
        chk("rst_suit", card_suit, 0);
        chk("rst_points", card_points, 0);
        chk("rst_err", draw_err, 0);
        chk("rst_ready", deck_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_cards_left", cards_left, 0);
        rst = 1'b0;

        // Draw from EMPTY is rejected
        draw_expect_err("empty_draw");
        chk("empty_cards_left", cards_left, 0);
        @(negedge clk);
        chk("err_one_cycle", draw_err, 0);
        repeat (98) @(negedge clk);

        // Shuffle with ignored shuffle_req pulses in FILL and SHUFFLE
        start_shuffle(ncyc);
        wait_ready(1'b1, 1'b0, ncyc);

        // Full deal and deck content checks
        deal(52);
        chk("empty_after_deal", deck_ready, 0);
        chk("empty_busy", busy, 0);
        for (int k = 0; k < 52; k++) seen[k] = 0;
        for (int k = 0; k < 14; k++) rank_cnt[k] = 0;
        aces = 0; dups = 0; bad = 0;
        for (int k = 0; k < 52; k++) begin
            if (got_rank[k] >= 1 && got_rank[k] <= 13) begin
                seen[got_suit[k] * 13 + got_rank[k] - 1]++;
                rank_cnt[got_rank[k]]++;
                if (got_rank[k] == 1) aces++;
            end else begin
                bad++;
            end
        end
        for (int k = 0; k < 52; k++) if (seen[k] != 1) dups++;
        chk("unique_bad_rank", bad, 0);
        chk("unique_dups", dups, 0);
        chk("unique_aces", aces, 4);
        for (int rk = 1; rk <= 13; rk++) chk("rank_count", rank_cnt[rk], 4);
        draw_expect_err("draw_53");
        chk("draw_53_left", cards_left, 0);

        // Mid-deck reshuffle with a simultaneous draw, plus a draw during FILL
        start_shuffle(ncyc);
        wait_ready(1'b0, 1'b1, ncyc);
        deal(10);
        shuffle_req = 1'b1;
        draw_req    = 1'b1;
        build_model(lfsr_m, ncyc);
        l0 = lfsr_m;
        @(negedge clk);
        shuffle_req = 1'b0;
        draw_req    = 1'b0;
        chk("mid_draw_err", draw_err, 1);
        chk("mid_valid", card_valid, 0);
        chk("mid_busy", busy, 1);
        chk("mid_cards_left", cards_left, 0);
        chk("mid_hold_rank", card_rank, got_rank[9]);
        chk("mid_hold_suit", card_suit, got_suit[9]);
        wait_ready(1'b0, 1'b0, ncyc);
        deal(52);

        // Same seed and same request cycle after a fresh reset
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        start_shuffle(ncyc);
        wait_ready(1'b0, 1'b0, ncyc);
        deal(52);

        // Reset during SHUFFLE
        start_shuffle(ncyc);
        repeat (70) @(negedge clk);
        chk("pre_rst_busy", busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_valid", card_valid, 0);
        chk("midrst_rank", card_rank, 0);
        chk("midrst_suit", card_suit, 0);
        chk("midrst_points", card_points, 0);
        chk("midrst_ace", card_is_ace, 0);
        chk("midrst_err", draw_err, 0);
        chk("midrst_ready", deck_ready, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_cards_left", cards_left, 0);
        draw_expect_err("midrst_draw");
        chk("midrst_still_idle", busy, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/card_dealer.md
Name: card_dealer

Overview:
- Deck server for the blackjack datapath. Holds a 52-card deck in a register array and shuffles it in hardware with an LFSR-driven Fisher-Yates algorithm.
- Returns one card per draw request to the game FSM.
- It is the supply side of the card-draw interface: the game controller asks for a card, and this block answers.
- It replaces ad-hoc per-slot LFSR deck generation with a deck that has no duplicate cards.

Parameters:
- DECK_SIZE, 52, number of cards; must be 13*k with k ≤ 4.
- IDX_W, 6, index width; 2^IDX_W ≥ DECK_SIZE.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be nonzero.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst  input  1  synchronous, active-high reset.
- shuffle_req  input  1  one-cycle pulse; refill and reshuffle the deck.
- draw_req  input  1  one-cycle pulse; request the next card.
- card_valid  output  1  one-cycle pulse; card_* outputs are updated.
- card_rank  output  4  1..13 (1 = ace, 11..13 = J, Q, K).
- card_suit  output  2  0..3.
- card_points  output  5  blackjack value: ace = 1, 2..10 = face value, J/Q/K = 10.
- card_is_ace  output  1  rank == 1.
- draw_err  output  1  one-cycle pulse; draw was rejected.
- deck_ready  output  1  high only in READY.
- busy  output  1  high in FILL or SHUFFLE.
- cards_left  output  IDX_W  undealt cards remaining.

Behaviour:
Reset (rst=1 sampled at posedge):
- State = EMPTY, lfsr = LFSR_SEED, cards_left = 0.
- All card_* outputs = 0; card_valid = draw_err = deck_ready = busy = 0.
- Reset mid-FILL or mid-SHUFFLE abandons the operation. Deck contents are don't-care afterwards.

LFSR:
- 16-bit Galois LFSR, taps x^16+x^14+x^13+x^11+1.
- Steps every cycle while not in reset. Shuffle outcome therefore depends on the cycle at which shuffle_req arrives.

States:
- EMPTY: shuffle_req -> FILL with k=0.
- FILL: writes deck[k] = {suit = k/13, rank = k%13 + 1}, one entry per cycle, for k = 0..DECK_SIZE-1 (DECK_SIZE cycles). Then -> SHUFFLE with i = DECK_SIZE-1.
- SHUFFLE, each cycle:
  - j = lfsr[IDX_W-1:0] & mask(i), where mask(i) = smallest 2^n-1 ≥ i.
  - If j ≤ i: swap deck[i] and deck[j] in the same cycle, then decrement i.
  - Otherwise retry on the next cycle.
  - When i reaches 0: set cards_left = DECK_SIZE and rd_ptr = 0, then -> READY.
- READY:
  - draw_req with cards_left > 0: next cycle card_valid = 1, outputs = deck[rd_ptr], rd_ptr++, cards_left--.
  - Draw that leaves cards_left = 0: -> EMPTY.
- card_* outputs hold their value until the next accepted draw or reset.

Rules:
- Draw latency is exactly 1 cycle. Back-to-back draw_req on consecutive cycles is accepted, one card per cycle.
- draw_req in EMPTY, FILL or SHUFFLE: no card is issued, and draw_err pulses the next cycle.
- shuffle_req in READY: restart FILL, discarding remaining cards; cards_left = 0 during FILL and SHUFFLE.
- shuffle_req in FILL or SHUFFLE: ignored.
- shuffle_req and draw_req in the same cycle in READY: shuffle wins; the draw gets draw_err and card_valid stays 0.
- card_points is combinational from the registered rank.

Decomposition:
- Package dealer_pkg:
  - DECK_SIZE, RANKS = 13
  - card_t = {suit[1:0], rank[3:0]}
  - dealer_state_t {EMPTY, FILL, SHUFFLE, READY}
  - function rank_to_points
- Sub-module lfsr16 (clk, rst, seed, out[15:0]), reusable by other game blocks.

Test Plan:
- Reset, then draw_req -> draw_err = 1 one cycle later; card_valid = 0; cards_left = 0.
- shuffle_req 100 cycles after reset -> busy = 1 for at least 52+51 cycles, then deck_ready = 1 and cards_left = 52.
- Uniqueness: after the shuffle, 52 consecutive draw_req -> 52 card_valid pulses with all {suit, rank} pairs distinct. Each rank appears 4 times and exactly 4 have card_is_ace = 1. Final state EMPTY; a 53rd draw gives draw_err.
- Points: every drawn rank of 11, 12 or 13 -> card_points = 10; rank 1 -> 1; rank 7 -> 7.
- Mid-deck: draw 10 cards, then pulse shuffle_req and draw_req together -> draw_err = 1, busy = 1, cards_left = 0; after completion cards_left = 52.
- Reproducibility: same LFSR_SEED and same shuffle_req cycle across two runs -> identical card sequence. Asserting rst mid-SHUFFLE -> next cycle state EMPTY and all outputs 0.
